// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM clock and framing generator.
package i2s_pkg;

    typedef enum logic [1:0] {
        I2S_MODE_I2S,
        I2S_MODE_LJ,
        I2S_MODE_TDM
    } i2s_mode_e;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_tick_div.sv
// Modulo-N counter with synchronous clear, advanced by inc; pulses tick on
// the wrap cycle and flips tgl on every wrap.
module i2s_tick_div
    import i2s_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tick,
    output logic tgl
);

    localparam int           W    = idx_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign tick = inc && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            tgl <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            tgl <= ~tgl;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_clock_gen.sv
// I2S / left-justified / TDM clock and framing generator: MCLK, SCLK, LRCLK
// or frame sync, plus bit/slot position and SCLK edge strobes in the clk domain.
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int        MCLK_HALF_DIV = 1,
    parameter int        SCLK_DIV      = 8,
    parameter int        SLOT_BITS     = 32,
    parameter int        NUM_SLOTS     = 2,
    parameter i2s_mode_e MODE          = I2S_MODE_I2S
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    output logic                            line_in_mclk,
    output logic                            line_in_sclk,
    output logic                            line_in_lrclk,
    output logic                            sclk_rise,
    output logic                            sclk_fall,
    output logic                            frame_start,
    output logic [idx_width(SLOT_BITS)-1:0] bit_idx,
    output logic [idx_width(NUM_SLOTS)-1:0] slot_idx
);

    localparam int            BW        = idx_width(SLOT_BITS);
    localparam int            SW        = idx_width(NUM_SLOTS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SLOTS - 1);

    if (MCLK_HALF_DIV < 1) begin : g_bad_mclk_div
        $error("i2s_clock_gen: MCLK_HALF_DIV must be >= 1");
    end
    if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
        $error("i2s_clock_gen: SCLK_DIV must be even and >= 2");
    end
    if (SLOT_BITS < 2) begin : g_bad_slot_bits
        $error("i2s_clock_gen: SLOT_BITS must be >= 2");
    end
    if (NUM_SLOTS < 1) begin : g_bad_num_slots
        $error("i2s_clock_gen: NUM_SLOTS must be >= 1");
    end
    if (MODE != I2S_MODE_TDM && NUM_SLOTS != 2) begin : g_bad_stereo
        $error("i2s_clock_gen: I2S and LJ framing need NUM_SLOTS == 2");
    end

    logic            clr;
    logic            mclk_tick;
    logic            sclk_tick;
    logic            fall_evt;
    logic            wrap;
    logic [BW-1:0]   bit_nxt;
    logic [SW-1:0]   slot_nxt;
    logic            lrclk_nxt;

    assign clr = !en;

    i2s_tick_div #(.N(MCLK_HALF_DIV)) u_mclk_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (1'b1),
        .tick (mclk_tick),
        .tgl  (line_in_mclk)
    );

    // SCLK_DIV is even, so every SCLK toggle lands on an MCLK falling edge.
    i2s_tick_div #(.N(SCLK_DIV)) u_sclk_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (mclk_tick),
        .tick (sclk_tick),
        .tgl  (line_in_sclk)
    );

    assign fall_evt = sclk_tick && line_in_sclk;
    assign wrap     = (bit_idx == BIT_LAST) && (slot_idx == SLOT_LAST);

    // Frame position is held as (slot, bit); lrclk decodes the post-fall position.
    always_comb begin
        bit_nxt   = bit_idx + 1'b1;
        slot_nxt  = slot_idx;
        lrclk_nxt = 1'b0;
        if (bit_idx == BIT_LAST) begin
            bit_nxt  = '0;
            slot_nxt = wrap ? '0 : slot_idx + 1'b1;
        end
        case (MODE)
            I2S_MODE_I2S: lrclk_nxt = !((slot_nxt == SLOT_LAST && bit_nxt == BIT_LAST) ||
                                        (slot_nxt == '0 && bit_nxt != BIT_LAST));
            I2S_MODE_LJ:  lrclk_nxt = (slot_nxt == '0);
            I2S_MODE_TDM: lrclk_nxt = (slot_nxt == SLOT_LAST) && (bit_nxt == BIT_LAST);
            default:      lrclk_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sclk_rise     <= 1'b0;
            sclk_fall     <= 1'b0;
            frame_start   <= 1'b0;
            line_in_lrclk <= 1'b0;
            bit_idx       <= '0;
            slot_idx      <= '0;
        end else begin
            sclk_rise   <= sclk_tick && !line_in_sclk;
            sclk_fall   <= fall_evt;
            frame_start <= fall_evt && wrap;
            if (fall_evt) begin
                bit_idx       <= bit_nxt;
                slot_idx      <= slot_nxt;
                line_in_lrclk <= lrclk_nxt;
            end
        end
    end

endmodule
